// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 memory controller.
package mpmc10_pkg;

  // Bytes moved by one app beat; command addresses are aligned to this.
  localparam int STRIP_BYTES = 16;

  // app_cmd encodings.
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd0;

  // Strip sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    WRITE,
    READ_CMD,
    READ_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mpmc10_strip_counter.sv
// Strip command address register plus independent issue and return counters.
module mpmc10_strip_counter
  import mpmc10_pkg::*;
#(
  parameter int STRIP_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,       // load aligned address, clear both counts
  input  logic [31:0]        load_addr,
  input  logic               step,       // advance one strip, count one issued command
  input  logic               ret_inc,    // count one returned strip
  output logic [31:0]        addr,
  output logic [STRIP_W-1:0] issue_cnt,
  output logic [STRIP_W-1:0] ret_cnt
);

  // Clearing the low bits keeps every command strip-aligned; the add wraps
  // modulo 2^32 and the carry out is simply lost.
  localparam logic [31:0] STRIP_MASK = ~(32'(STRIP_BYTES) - 32'd1);

  // Address and counters update on load, step and return events.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      addr      <= 32'h1FFF_FFFF;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (load) begin
        addr      <= load_addr & STRIP_MASK;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (step) begin
          addr      <= (addr & STRIP_MASK) + 32'(STRIP_BYTES);
          issue_cnt <= issue_cnt + STRIP_W'(1);
        end
        if (ret_inc) begin
          ret_cnt <= ret_cnt + STRIP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mpmc10_strip_sequencer.sv
// Turns one write strip or one read burst into DDR app commands and returns
// read strips tagged with their index.
module mpmc10_strip_sequencer
  import mpmc10_pkg::*;
#(
  parameter int STRIP_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               calib_complete,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_adr,
  input  logic [STRIP_W-1:0] req_num_strips,
  input  logic [127:0]       req_wdata,
  input  logic [15:0]        req_wmask,
  output logic               app_en,
  output logic [2:0]         app_cmd,
  output logic [31:0]        app_addr,
  input  logic               app_rdy,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  output logic [127:0]       app_wdf_data,
  output logic [15:0]        app_wdf_mask,
  input  logic               app_wdf_rdy,
  input  logic               app_rd_data_valid,
  input  logic [127:0]       app_rd_data,
  output logic               resp_valid,
  output logic [127:0]       resp_data,
  output logic [STRIP_W-1:0] resp_strip,
  output logic               resp_done,
  output logic               busy
);

  state_t               state;
  logic                 lat_we;
  logic [31:0]          lat_adr;
  logic [STRIP_W-1:0]   lat_num;
  logic [STRIP_W-1:0]   issue_cnt;
  logic [STRIP_W-1:0]   ret_cnt;
  logic                 accept;
  logic                 cmd_hs;
  logic                 wdf_hs;
  logic                 last_issue;
  logic                 in_read;
  logic                 ret_beat;
  logic                 cnt_step;

  assign req_ready   = (state == IDLE) && calib_complete;
  assign accept      = req_valid && req_ready;
  assign cmd_hs      = app_en && app_rdy;
  assign wdf_hs      = app_wdf_wren && app_wdf_rdy;
  assign last_issue  = (issue_cnt == lat_num);
  assign in_read     = (state == READ_CMD) || (state == READ_WAIT);
  // Returns are only meaningful while a read is in flight; elsewhere they are dropped.
  assign ret_beat    = in_read && app_rd_data_valid;
  assign cnt_step    = (state == READ_CMD) && cmd_hs && !last_issue;
  assign app_wdf_end = app_wdf_wren;

  mpmc10_strip_counter #(
    .STRIP_W (STRIP_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (state == PRESET),
    .load_addr (lat_adr),
    .step      (cnt_step),
    .ret_inc   (ret_beat),
    .addr      (app_addr),
    .issue_cnt (issue_cnt),
    .ret_cnt   (ret_cnt)
  );

  // Transaction FSM: request latch, registered app command/write-data drivers, completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_adr      <= '0;
      lat_num      <= '0;
      app_en       <= 1'b0;
      app_cmd      <= CMD_WRITE;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      resp_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_we       <= req_we;
            lat_adr      <= req_adr;
            lat_num      <= req_we ? '0 : req_num_strips;
            app_wdf_data <= req_wdata;
            app_wdf_mask <= req_wmask;
            busy         <= 1'b1;
            state        <= PRESET;
          end
        end
        PRESET: begin
          app_en       <= 1'b1;
          app_cmd      <= lat_we ? CMD_WRITE : CMD_READ;
          app_wdf_wren <= lat_we;
          state        <= lat_we ? WRITE : READ_CMD;
        end
        WRITE: begin
          // Command and data channels retire independently; leave once both have.
          if (cmd_hs) app_en       <= 1'b0;
          if (wdf_hs) app_wdf_wren <= 1'b0;
          if ((cmd_hs || !app_en) && (wdf_hs || !app_wdf_wren)) begin
            resp_done <= 1'b1;
            state     <= DONE;
          end
        end
        READ_CMD: begin
          if (cmd_hs && last_issue) begin
            app_en <= 1'b0;
            state  <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (app_rd_data_valid && (ret_cnt == lat_num)) begin
            resp_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered copy of each accepted read return, tagged with its strip index.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_strip <= '0;
    end else begin
      resp_valid <= ret_beat;
      if (ret_beat) begin
        resp_data  <= app_rd_data;
        resp_strip <= ret_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mpmc10_strip_sequencer.sv
// Directed self-checking bench for mpmc10_strip_sequencer.
module tb_mpmc10_strip_sequencer;
  import mpmc10_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         calib_complete;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_adr;
  logic [5:0]   req_num_strips;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [31:0]  app_addr;
  logic         app_rdy;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic         app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic [5:0]   resp_strip;
  logic         resp_done;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-read observations gathered by run_read.
  logic [31:0] cmd_q[$];
  int          cmd_cyc_q[$];
  int          strip_q[$];
  int          done_cnt;
  int          done_cyc;
  int          last_resp_cyc;
  int          bad_cmd;
  int          bad_data;

  always #5 clk = ~clk;

  mpmc10_strip_sequencer #(.STRIP_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .calib_complete    (calib_complete),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_adr           (req_adr),
    .req_num_strips    (req_num_strips),
    .req_wdata         (req_wdata),
    .req_wmask         (req_wmask),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_rdy           (app_rdy),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask      (app_wdf_mask),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data       (app_rd_data),
    .resp_valid        (resp_valid),
    .resp_data         (resp_data),
    .resp_strip        (resp_strip),
    .resp_done         (resp_done),
    .busy              (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Present one request from an idle DUT; returns #1 after the accepting edge.
  task automatic send_req(input logic we, input logic [31:0] adr, input logic [5:0] num,
                          input logic [127:0] wdata, input logic [15:0] wmask);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_num_strips = num;
    req_wdata = wdata; req_wmask = wmask;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL accept: req_ready=%b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Memory stand-in: returns one beat per cycle for each command accepted earlier.
  task automatic run_read(input logic [31:0] adr, input logic [5:0] num, input bit toggle);
    int pend = 0;
    int ret_idx = 0;
    bit done_seen = 0;
    logic [31:0] w;
    cmd_q.delete(); cmd_cyc_q.delete(); strip_q.delete();
    done_cnt = 0; done_cyc = -1; last_resp_cyc = -2; bad_cmd = 0; bad_data = 0;
    send_req(1'b0, adr, num, '0, '0);
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        w = 32'hC0DE_0000 + 32'(strip_q.size());
        if (resp_data !== {4{w}}) bad_data++;
        strip_q.push_back(int'(resp_strip));
        last_resp_cyc = cyc;
      end
      if (resp_done) begin done_cnt++; done_cyc = cyc; done_seen = 1; end
      app_rdy = toggle ? cyc[0] : 1'b1;
      app_rd_data_valid = (pend > 0);
      if (pend > 0) begin
        w = 32'hC0DE_0000 + 32'(ret_idx);
        app_rd_data = {4{w}};
        ret_idx++; pend--;
      end
      if (app_en && app_rdy) begin
        cmd_q.push_back(app_addr); cmd_cyc_q.push_back(cyc);
        if (app_cmd !== CMD_READ) bad_cmd++;
        pend++;
      end
    end
    app_rdy = 1'b0; app_rd_data_valid = 1'b0;
    tests_run++;
    if (!done_seen) begin
      tests_failed++; $display("FAIL read_timeout: resp_done not seen (adr=%h num=%0d)", adr, num);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL idle_after_done: busy=%b req_ready=%b expected 0/1", busy, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; calib_complete = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0;
    req_num_strips = '0; req_wdata = '0; req_wmask = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (app_addr !== 32'h1FFF_FFFF) begin
      tests_failed++; $display("FAIL reset_addr: app_addr=%h expected 1fffffff", app_addr);
    end
    tests_run++;
    if ({app_en, app_wdf_wren, app_wdf_end, resp_valid, resp_done, busy, req_ready} !== 7'b0) begin
      tests_failed++; $display("FAIL reset_outputs: en=%b wren=%b end=%b rv=%b done=%b busy=%b rdy=%b expected all 0",
                               app_en, app_wdf_wren, app_wdf_end, resp_valid, resp_done, busy, req_ready);
    end
    rst = 1'b0; calib_complete = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_burst4();
    logic [31:0] exp_addr [4] = '{32'h1230, 32'h1240, 32'h1250, 32'h1260};
    run_read(32'h0000_1238, 6'd3, 1'b0);
    tests_run++;
    if (cmd_q.size() != 4 || bad_cmd != 0) begin
      tests_failed++; $display("FAIL rd4_cmds: count=%0d bad_cmd=%0d expected 4/0", cmd_q.size(), bad_cmd);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= cmd_q.size() || cmd_q[i] !== exp_addr[i] || cmd_cyc_q[i] != i) begin
        tests_failed++; $display("FAIL rd4_addr%0d: addr/cycle wrong, expected %h at cycle %0d", i, exp_addr[i], i);
      end
    end
    tests_run++;
    if (strip_q.size() != 4 || bad_data != 0) begin
      tests_failed++; $display("FAIL rd4_resp: count=%0d bad_data=%0d expected 4/0", strip_q.size(), bad_data);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= strip_q.size() || strip_q[i] != i) begin
        tests_failed++; $display("FAIL rd4_strip%0d: strip out of order, expected %0d", i, i);
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != last_resp_cyc) begin
      tests_failed++; $display("FAIL rd4_done: count=%0d cyc=%0d expected 1 at cyc %0d", done_cnt, done_cyc, last_resp_cyc);
    end
  endtask

  task automatic test_write_split();
    send_req(1'b1, 32'h0000_0100, 6'd5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h00F0);
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_addr !== 32'h100 || app_cmd !== CMD_WRITE) begin
      tests_failed++; $display("FAIL wr_start: en=%b wren=%b end=%b addr=%h cmd=%0d expected 1/1/1/100/0",
                               app_en, app_wdf_wren, app_wdf_end, app_addr, app_cmd);
    end
    tests_run++;
    if (app_wdf_data !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 || app_wdf_mask !== 16'h00F0) begin
      tests_failed++; $display("FAIL wr_data: data=%h mask=%h", app_wdf_data, app_wdf_mask);
    end
    app_wdf_rdy = 1'b1;
    @(posedge clk); #1;
    app_wdf_rdy = 1'b0;
    tests_run++;
    if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || app_en !== 1'b1) begin
      tests_failed++; $display("FAIL wr_wdf_drop: wren=%b end=%b en=%b expected 0/0/1", app_wdf_wren, app_wdf_end, app_en);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (app_en !== 1'b1 || resp_done !== 1'b0) begin
      tests_failed++; $display("FAIL wr_cmd_hold: en=%b done=%b expected 1/0", app_en, resp_done);
    end
    app_rdy = 1'b1;
    @(posedge clk); #1;
    app_rdy = 1'b0;
    tests_run++;
    if (app_en !== 1'b0 || resp_done !== 1'b1) begin
      tests_failed++; $display("FAIL wr_done: en=%b done=%b expected 0/1", app_en, resp_done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (resp_done !== 1'b0 || busy !== 1'b0 || app_en !== 1'b0) begin
      tests_failed++; $display("FAIL wr_idle: done=%b busy=%b en=%b expected 0/0/0", resp_done, busy, app_en);
    end
  endtask

  task automatic test_write_same_cycle();
    send_req(1'b1, 32'h0000_0208, 6'd0, {4{32'h5A5A_A5A5}}, 16'h0001);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_addr !== 32'h200) begin
      tests_failed++; $display("FAIL wr2_start: en=%b wren=%b addr=%h expected 1/1/200", app_en, app_wdf_wren, app_addr);
    end
    @(posedge clk); #1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    tests_run++;
    if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || resp_done !== 1'b1) begin
      tests_failed++; $display("FAIL wr2_done: en=%b wren=%b done=%b expected 0/0/1", app_en, app_wdf_wren, resp_done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || resp_done !== 1'b0) begin
      tests_failed++; $display("FAIL wr2_idle: busy=%b done=%b expected 0/0", busy, resp_done);
    end
  endtask

  task automatic test_read_single_top();
    run_read(32'hFFFF_FFF0, 6'd0, 1'b0);
    tests_run++;
    if (cmd_q.size() != 1 || cmd_q[0] !== 32'hFFFF_FFF0 || bad_cmd != 0) begin
      tests_failed++; $display("FAIL rd1_cmd: count=%0d expected 1 command at fffffff0", cmd_q.size());
    end
    tests_run++;
    if (strip_q.size() != 1 || strip_q[0] != 0 || done_cnt != 1 || bad_data != 0) begin
      tests_failed++; $display("FAIL rd1_resp: resp=%0d done=%0d bad_data=%0d expected 1/1/0", strip_q.size(), done_cnt, bad_data);
    end
  endtask

  task automatic test_read_wrap();
    run_read(32'hFFFF_FFF7, 6'd1, 1'b0);
    tests_run++;
    if (cmd_q.size() != 2 || cmd_q[0] !== 32'hFFFF_FFF0 || cmd_q[1] !== 32'h0000_0000) begin
      tests_failed++; $display("FAIL rd_wrap: count=%0d expected fffffff0 then 00000000", cmd_q.size());
    end
    tests_run++;
    if (strip_q.size() != 2 || strip_q[0] != 0 || strip_q[1] != 1 || done_cnt != 1) begin
      tests_failed++; $display("FAIL rd_wrap_resp: resp=%0d done=%0d expected 2/1", strip_q.size(), done_cnt);
    end
  endtask

  task automatic test_read_toggle8();
    logic [31:0] exp;
    run_read(32'h0000_8000, 6'd7, 1'b1);
    tests_run++;
    if (cmd_q.size() != 8 || bad_cmd != 0) begin
      tests_failed++; $display("FAIL rd8_cmds: count=%0d bad_cmd=%0d expected 8/0", cmd_q.size(), bad_cmd);
    end
    for (int i = 0; i < 8; i++) begin
      exp = 32'h0000_8000 + 32'(16 * i);
      tests_run++;
      if (i >= cmd_q.size() || cmd_q[i] !== exp) begin
        tests_failed++; $display("FAIL rd8_addr%0d: expected %h", i, exp);
      end
    end
    tests_run++;
    if (strip_q.size() != 8 || bad_data != 0 || done_cnt != 1) begin
      tests_failed++; $display("FAIL rd8_resp: resp=%0d bad_data=%0d done=%0d expected 8/0/1", strip_q.size(), bad_data, done_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (i >= strip_q.size() || strip_q[i] != i) begin
        tests_failed++; $display("FAIL rd8_strip%0d: strip out of order, expected %0d", i, i);
      end
    end
  endtask

  task automatic test_calib_gate();
    int dones = 0;
    calib_complete = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h0000_0300; req_num_strips = '0;
    req_wdata = {4{32'h1111_2222}}; req_wmask = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (req_ready !== 1'b0 || app_en !== 1'b0 || busy !== 1'b0) begin
        tests_failed++; $display("FAIL calib_block%0d: rdy=%b en=%b busy=%b expected 0/0/0", i, req_ready, app_en, busy);
      end
    end
    calib_complete = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL calib_ready: req_ready=%b expected 1", req_ready);
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL calib_accept: busy=%b expected 1", busy);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_done) dones++;
    end
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    tests_run++;
    if (dones != 1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL calib_done: dones=%0d busy=%b expected 1/0", dones, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    send_req(1'b0, 32'h0000_4000, 6'd15, '0, '0);
    app_rdy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if (app_en !== 1'b1 || app_addr !== 32'h0000_4020) begin
      tests_failed++; $display("FAIL rst_pre: en=%b addr=%h expected 1/00004020", app_en, app_addr);
    end
    rst = 1'b1; app_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || app_en !== 1'b0 || app_addr !== 32'h1FFF_FFFF) begin
      tests_failed++; $display("FAIL rst_mid: busy=%b en=%b addr=%h expected 0/0/1fffffff", busy, app_en, app_addr);
    end
    app_rd_data_valid = 1'b1; app_rd_data = {4{32'hDEAD_BEEF}};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++; $display("FAIL rst_stray%0d: resp_valid=%b busy=%b expected 0/0", i, resp_valid, busy);
      end
    end
    app_rd_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read_burst4();
    test_write_split();
    test_write_same_cycle();
    test_read_single_top();
    test_read_wrap();
    test_read_toggle8();
    test_calib_gate();
    test_reset_mid_burst();
    test_read_burst4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
